cp0_tlb_timer: RTL and testbench



---
 rtl/cp0_tlb_timer.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_cp0_tlb_timer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_tlb_timer.sv
// ============================================================================
// Module   : cp0_tlb_timer
// Purpose  : MIPS system-control coprocessor (CP0). Holds the TLB helper
//            registers (Index, Random, Wired, EntryLo0/1, EntryHi), the
//            exception state (BadVAddr, Status, Cause, EPC) and a Count/
//            Compare timer. Prioritises exceptions and interrupts, and
//            supplies the trap vector and the ERET target to fetch.
// Ports    :
//   clk, reset                 clock, synchronous active-high reset
//   cpu_pause_i                freezes all state, blocks exception accept
//   cp0_wen_i/addr_i/data_i    MTC0 strobe, register number, write data
//   cp0_data_o                 MFC0 combinational read of cp0_addr_i
//   instr_eret_i/syscall_i     ERET / SYSCALL at MEM
//   exc_*_i, exc_rw_i          memory exceptions, 1 = store / 0 = load
//   epc_i, badvaddr_i          faulting PC / faulting virtual address
//   tlb_probe_*_i              TLBP result
//   hw_int_i                   level-sensitive external interrupts
//   exc_taken_o, exc_vector_o  exception accepted this cycle and its target
//   cp0_*_o                    live register values
//   timer_int_o                Cause.TI
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_tlb_timer #(
    parameter int TLB_ENTRIES = 16,
    parameter int N_HW_INT    = 6,
    parameter int COUNT_DIV   = 2,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_pause_i,
    input  logic             cp0_wen_i,
    input  logic [4:0]       cp0_addr_i,
    input  logic [31:0]      cp0_data_i,
    output logic [31:0]      cp0_data_o,
    input  logic             instr_eret_i,
    input  logic             instr_syscall_i,
    input  logic             exc_addr_error_i,
    input  logic             exc_tlb_mod_i,
    input  logic             exc_tlb_refill_i,
    input  logic             exc_tlb_invalid_i,
    input  logic             exc_rw_i,
    input  logic [31:0]      epc_i,
    input  logic [31:0]      badvaddr_i,
    input  logic             tlb_probe_valid_i,
    input  logic             tlb_probe_hit_i,
    input  logic [IDX_W-1:0] tlb_probe_index_i,
    input  logic [N_HW_INT-1:0] hw_int_i,
    output logic             exc_taken_o,
    output logic [31:0]      exc_vector_o,
    output logic [31:0]      cp0_epc_o,
    output logic [31:0]      cp0_status_o,
    output logic [31:0]      cp0_cause_o,
    output logic [31:0]      cp0_index_o,
    output logic [31:0]      cp0_random_o,
    output logic [31:0]      cp0_entryhi_o,
    output logic             timer_int_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [4:0] c_REG_INDEX    = 5'd0;
    localparam logic [4:0] c_REG_RANDOM   = 5'd1;
    localparam logic [4:0] c_REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] c_REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] c_REG_WIRED    = 5'd6;
    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_ENTRYHI  = 5'd10;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;

    localparam logic [4:0] c_EXC_INT  = 5'd0;
    localparam logic [4:0] c_EXC_MOD  = 5'd1;
    localparam logic [4:0] c_EXC_TLBL = 5'd2;
    localparam logic [4:0] c_EXC_TLBS = 5'd3;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_SYS  = 5'd8;

    localparam logic [31:0] c_VEC_REFILL  = 32'h8000_0000;
    localparam logic [31:0] c_VEC_GENERAL = 32'h8000_0180;

    localparam int              PS_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PS_W-1:0] c_PS_LAST  = PS_W'(COUNT_DIV - 1);
    localparam logic [IDX_W-1:0] c_RND_TOP = IDX_W'(TLB_ENTRIES - 1);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic             r_index_p;
    logic [IDX_W-1:0] r_index_idx;
    logic [IDX_W-1:0] r_random;
    logic [31:0]      r_wired;
    logic [25:0]      r_entrylo0;
    logic [25:0]      r_entrylo1;
    logic [18:0]      r_vpn2;
    logic [7:0]       r_asid;
    logic [31:0]      r_badvaddr;
    logic [31:0]      r_count;
    logic [PS_W-1:0]  r_presc;
    logic [31:0]      r_compare;
    logic [7:0]       r_im;
    logic             r_um;
    logic             r_exl;
    logic             r_ie;
    logic             r_ti;
    logic [1:0]       r_ip_sw;
    logic [4:0]       r_exccode;
    logic [31:0]      r_epc;

    // ------------------------------------------------------------------
    // Interrupt lines and pending logic
    // ------------------------------------------------------------------
    logic [5:0] w_hw;
    logic [7:0] w_ip;
    logic       w_int_pend;

    // Zero-extend the external lines to the six hardware IP slots.
    always_comb begin
        w_hw                 = '0;
        w_hw[N_HW_INT-1:0]   = hw_int_i;
    end

    // IP[7] is shared between the top hardware line and the timer.
    assign w_ip       = {w_hw[5] | r_ti, w_hw[4:0], r_ip_sw};
    assign w_int_pend = (|(w_ip & r_im)) && r_ie && !r_exl;

    // ------------------------------------------------------------------
    // Exception prioritisation
    // ------------------------------------------------------------------
    logic       w_any_exc;
    logic       w_exc_taken;
    logic [4:0] w_code;
    logic       w_sel_tlb;
    logic       w_sel_badv;
    logic       w_sel_refill;

    assign w_any_exc = w_int_pend | exc_addr_error_i | exc_tlb_mod_i |
                       exc_tlb_refill_i | exc_tlb_invalid_i | instr_syscall_i;
    assign w_exc_taken = !cpu_pause_i && w_any_exc;

    always_comb begin
        w_code       = c_EXC_SYS;
        w_sel_tlb    = 1'b0;
        w_sel_badv   = 1'b0;
        w_sel_refill = 1'b0;
        if (w_int_pend) begin
            w_code = c_EXC_INT;
        end else if (exc_addr_error_i) begin
            w_code     = exc_rw_i ? c_EXC_ADES : c_EXC_ADEL;
            w_sel_badv = 1'b1;
        end else if (exc_tlb_mod_i) begin
            w_code     = c_EXC_MOD;
            w_sel_badv = 1'b1;
            w_sel_tlb  = 1'b1;
        end else if (exc_tlb_refill_i) begin
            w_code       = exc_rw_i ? c_EXC_TLBS : c_EXC_TLBL;
            w_sel_badv   = 1'b1;
            w_sel_tlb    = 1'b1;
            w_sel_refill = 1'b1;
        end else if (exc_tlb_invalid_i) begin
            w_code     = exc_rw_i ? c_EXC_TLBS : c_EXC_TLBL;
            w_sel_badv = 1'b1;
            w_sel_tlb  = 1'b1;
        end
    end

    // The dedicated refill vector is only used for a first-level refill;
    // a nested refill goes through the general handler.
    assign exc_taken_o  = w_exc_taken;
    assign exc_vector_o = (w_sel_refill && !r_exl) ? c_VEC_REFILL : c_VEC_GENERAL;

    // ------------------------------------------------------------------
    // Write qualifiers, timer tick, Random next value
    // ------------------------------------------------------------------
    logic             w_wr;
    logic             w_tick;
    logic             w_wired_wr;
    logic [IDX_W-1:0] w_random_nxt;

    // An accepted exception drops a same-cycle MTC0.
    assign w_wr       = cp0_wen_i && !cpu_pause_i && !w_exc_taken;
    assign w_wired_wr = w_wr && (cp0_addr_i == c_REG_WIRED);
    assign w_tick     = (r_presc == c_PS_LAST);

    always_comb begin
        w_random_nxt = r_random - 1'b1;
        if (w_wired_wr || (r_wired >= 32'(TLB_ENTRIES)) ||
            (32'(r_random) <= r_wired)) begin
            w_random_nxt = c_RND_TOP;
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index_p   <= 1'b0;
            r_index_idx <= '0;
            r_random    <= c_RND_TOP;
            r_wired     <= '0;
            r_entrylo0  <= '0;
            r_entrylo1  <= '0;
            r_vpn2      <= '0;
            r_asid      <= '0;
            r_badvaddr  <= '0;
            r_count     <= '0;
            r_presc     <= '0;
            r_compare   <= 32'hFFFF_FFFF;
            r_im        <= '0;
            r_um        <= 1'b0;
            r_exl       <= 1'b1;
            r_ie        <= 1'b0;
            r_ti        <= 1'b0;
            r_ip_sw     <= '0;
            r_exccode   <= '0;
            r_epc       <= '0;
        end else if (!cpu_pause_i) begin
            // Random / Wired
            r_random <= w_random_nxt;
            if (w_wired_wr) begin
                r_wired <= cp0_data_i;
            end

            // Count with prescaler. A Count write also restarts the
            // prescaler so the first increment is a full period away.
            if (w_wr && (cp0_addr_i == c_REG_COUNT)) begin
                r_count <= cp0_data_i;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= r_count + 32'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Compare / TI: a Compare write clears TI even on a match.
            if (w_wr && (cp0_addr_i == c_REG_COMPARE)) begin
                r_compare <= cp0_data_i;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end

            // EntryLo
            if (w_wr && (cp0_addr_i == c_REG_ENTRYLO0)) begin
                r_entrylo0 <= cp0_data_i[25:0];
            end
            if (w_wr && (cp0_addr_i == c_REG_ENTRYLO1)) begin
                r_entrylo1 <= cp0_data_i[25:0];
            end

            // Index: a probe result takes precedence over MTC0.
            if (tlb_probe_valid_i) begin
                r_index_p <= !tlb_probe_hit_i;
                if (tlb_probe_hit_i) begin
                    r_index_idx <= tlb_probe_index_i;
                end
            end else if (w_wr && (cp0_addr_i == c_REG_INDEX)) begin
                r_index_idx <= cp0_data_i[IDX_W-1:0];
            end

            // EntryHi
            if (w_exc_taken && w_sel_tlb) begin
                r_vpn2 <= badvaddr_i[31:13];
            end else if (w_wr && (cp0_addr_i == c_REG_ENTRYHI)) begin
                r_vpn2 <= cp0_data_i[31:13];
                r_asid <= cp0_data_i[7:0];
            end

            // BadVAddr is read-only to software.
            if (w_exc_taken && w_sel_badv) begin
                r_badvaddr <= badvaddr_i;
            end

            // EPC: nested exceptions keep the original return address.
            if (w_exc_taken) begin
                if (!r_exl) begin
                    r_epc <= epc_i;
                end
            end else if (w_wr && (cp0_addr_i == c_REG_EPC)) begin
                r_epc <= cp0_data_i;
            end

            // Status / Cause
            if (w_exc_taken) begin
                r_exl     <= 1'b1;
                r_exccode <= w_code;
            end else begin
                if (w_wr && (cp0_addr_i == c_REG_STATUS)) begin
                    r_im  <= cp0_data_i[15:8];
                    r_um  <= cp0_data_i[4];
                    r_exl <= cp0_data_i[1];
                    r_ie  <= cp0_data_i[0];
                end
                if (w_wr && (cp0_addr_i == c_REG_CAUSE)) begin
                    r_ip_sw <= cp0_data_i[9:8];
                end
                if (instr_eret_i) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register views and MFC0 read mux
    // ------------------------------------------------------------------
    assign cp0_status_o  = {16'b0, r_im, 3'b0, r_um, 2'b0, r_exl, r_ie};
    assign cp0_cause_o   = {1'b0, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
    assign cp0_index_o   = {r_index_p, {(31-IDX_W){1'b0}}, r_index_idx};
    assign cp0_random_o  = {{(32-IDX_W){1'b0}}, r_random};
    assign cp0_entryhi_o = {r_vpn2, 5'b0, r_asid};
    assign cp0_epc_o     = r_epc;
    assign timer_int_o   = r_ti;

    always_comb begin
        cp0_data_o = 32'd0;
        case (cp0_addr_i)
            c_REG_INDEX:    cp0_data_o = cp0_index_o;
            c_REG_RANDOM:   cp0_data_o = cp0_random_o;
            c_REG_ENTRYLO0: cp0_data_o = {6'b0, r_entrylo0};
            c_REG_ENTRYLO1: cp0_data_o = {6'b0, r_entrylo1};
            c_REG_WIRED:    cp0_data_o = r_wired;
            c_REG_BADVADDR: cp0_data_o = r_badvaddr;
            c_REG_COUNT:    cp0_data_o = r_count;
            c_REG_ENTRYHI:  cp0_data_o = cp0_entryhi_o;
            c_REG_COMPARE:  cp0_data_o = r_compare;
            c_REG_STATUS:   cp0_data_o = cp0_status_o;
            c_REG_CAUSE:    cp0_data_o = cp0_cause_o;
            c_REG_EPC:      cp0_data_o = r_epc;
            default:        cp0_data_o = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_tlb_timer.sv
// ============================================================================
// Module   : tb_cp0_tlb_timer
// Purpose  : Self-checking bench for cp0_tlb_timer: reset state, an
//            exception/interrupt priority table, ERET and collision cases,
//            the Count/Compare timer, Random/Wired and TLBP updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_tlb_timer;

    localparam int TLB_ENTRIES = 16;
    localparam int N_HW_INT    = 6;
    localparam int COUNT_DIV   = 2;
    localparam int IDX_W       = 4;

    logic                clk;
    logic                reset;
    logic                cpu_pause_i;
    logic                cp0_wen_i;
    logic [4:0]          cp0_addr_i;
    logic [31:0]         cp0_data_i;
    logic [31:0]         cp0_data_o;
    logic                instr_eret_i;
    logic                instr_syscall_i;
    logic                exc_addr_error_i;
    logic                exc_tlb_mod_i;
    logic                exc_tlb_refill_i;
    logic                exc_tlb_invalid_i;
    logic                exc_rw_i;
    logic [31:0]         epc_i;
    logic [31:0]         badvaddr_i;
    logic                tlb_probe_valid_i;
    logic                tlb_probe_hit_i;
    logic [IDX_W-1:0]    tlb_probe_index_i;
    logic [N_HW_INT-1:0] hw_int_i;
    logic                exc_taken_o;
    logic [31:0]         exc_vector_o;
    logic [31:0]         cp0_epc_o;
    logic [31:0]         cp0_status_o;
    logic [31:0]         cp0_cause_o;
    logic [31:0]         cp0_index_o;
    logic [31:0]         cp0_random_o;
    logic [31:0]         cp0_entryhi_o;
    logic                timer_int_o;

    cp0_tlb_timer #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .N_HW_INT    (N_HW_INT),
        .COUNT_DIV   (COUNT_DIV)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_pause_i       (cpu_pause_i),
        .cp0_wen_i         (cp0_wen_i),
        .cp0_addr_i        (cp0_addr_i),
        .cp0_data_i        (cp0_data_i),
        .cp0_data_o        (cp0_data_o),
        .instr_eret_i      (instr_eret_i),
        .instr_syscall_i   (instr_syscall_i),
        .exc_addr_error_i  (exc_addr_error_i),
        .exc_tlb_mod_i     (exc_tlb_mod_i),
        .exc_tlb_refill_i  (exc_tlb_refill_i),
        .exc_tlb_invalid_i (exc_tlb_invalid_i),
        .exc_rw_i          (exc_rw_i),
        .epc_i             (epc_i),
        .badvaddr_i        (badvaddr_i),
        .tlb_probe_valid_i (tlb_probe_valid_i),
        .tlb_probe_hit_i   (tlb_probe_hit_i),
        .tlb_probe_index_i (tlb_probe_index_i),
        .hw_int_i          (hw_int_i),
        .exc_taken_o       (exc_taken_o),
        .exc_vector_o      (exc_vector_o),
        .cp0_epc_o         (cp0_epc_o),
        .cp0_status_o      (cp0_status_o),
        .cp0_cause_o       (cp0_cause_o),
        .cp0_index_o       (cp0_index_o),
        .cp0_random_o      (cp0_random_o),
        .cp0_entryhi_o     (cp0_entryhi_o),
        .timer_int_o       (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pre_status;
        logic [5:0]  hw;
        logic        ae;
        logic        mod;
        logic        refill;
        logic        inval;
        logic        sys;
        logic        rw;
        logic [31:0] epc;
        logic [31:0] badv;
        logic        taken;
        logic [31:0] vec;
        logic [4:0]  code;
        logic        exl;
        logic [31:0] epc_exp;
        logic [31:0] badv_exp;
        logic [31:0] ehi_exp;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_wen_i  = 1'b1;
        cp0_addr_i = a;
        cp0_data_i = d;
        @(posedge clk); #1;
        cp0_wen_i  = 1'b0;
    endtask

    task automatic clear_exc();
        hw_int_i          = '0;
        exc_addr_error_i  = 1'b0;
        exc_tlb_mod_i     = 1'b0;
        exc_tlb_refill_i  = 1'b0;
        exc_tlb_invalid_i = 1'b0;
        instr_syscall_i   = 1'b0;
        instr_eret_i      = 1'b0;
        exc_rw_i          = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr_i = a;
        #1;
        check(name, cp0_data_o, exp);
    endtask

    initial begin
        vec_t e;
        int   n;
        logic [31:0] rnd_exp[5];

        // pre_status, hw, ae, mod, refill, inval, sys, rw, epc, badv,
        // taken, vec, code, exl, epc_exp, badv_exp, ehi_exp
        tbl[0]  = '{32'h0000_FC01, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,
                    1'b1, 32'h8000_0180, 5'd0, 1'b1, 32'h100, 32'h0, 32'h0};
        tbl[1]  = '{32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0040_3004,
                    1'b1, 32'h8000_0000, 5'd3, 1'b1, 32'h200, 32'h0040_3004, 32'h0040_2000};
        tbl[2]  = '{32'h0000_0002, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1234_5678,
                    1'b1, 32'h8000_0180, 5'd2, 1'b1, 32'h200, 32'h1234_5678, 32'h1234_4000};
        tbl[3]  = '{32'h0000_0000, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'hDEAD_0001,
                    1'b1, 32'h8000_0180, 5'd4, 1'b1, 32'h400, 32'hDEAD_0001, 32'h1234_4000};
        tbl[4]  = '{32'h0000_0000, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h8000_2000,
                    1'b1, 32'h8000_0180, 5'd1, 1'b1, 32'h500, 32'h8000_2000, 32'h8000_2000};
        tbl[5]  = '{32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0000_5555,
                    1'b1, 32'h8000_0180, 5'd8, 1'b1, 32'h600, 32'h8000_2000, 32'h8000_2000};
        tbl[6]  = '{32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0000_6000,
                    1'b1, 32'h8000_0180, 5'd3, 1'b1, 32'h700, 32'h0000_6000, 32'h0000_6000};
        tbl[7]  = '{32'h0000_FC00, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h0000_7777,
                    1'b1, 32'h8000_0180, 5'd8, 1'b1, 32'h800, 32'h0000_6000, 32'h0000_6000};
        tbl[8]  = '{32'h0000_FC03, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0,
                    1'b0, 32'h8000_0180, 5'd8, 1'b1, 32'h800, 32'h0000_6000, 32'h0000_6000};
        tbl[9]  = '{32'h0000_0401, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA00, 32'h0000_AAAA,
                    1'b1, 32'h8000_0180, 5'd0, 1'b1, 32'hA00, 32'h0000_6000, 32'h0000_6000};
        tbl[10] = '{32'h0000_0801, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB00, 32'h0,
                    1'b0, 32'h8000_0180, 5'd0, 1'b0, 32'hA00, 32'h0000_6000, 32'h0000_6000};

        reset             = 1'b1;
        cpu_pause_i       = 1'b0;
        cp0_wen_i         = 1'b0;
        cp0_addr_i        = '0;
        cp0_data_i        = '0;
        epc_i             = '0;
        badvaddr_i        = '0;
        tlb_probe_valid_i = 1'b0;
        tlb_probe_hit_i   = 1'b0;
        tlb_probe_index_i = '0;
        clear_exc();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_random",  cp0_random_o, 32'd15);
        check("rst_status",  cp0_status_o, 32'h0000_0002);
        check("rst_cause",   cp0_cause_o,  32'h0);
        check("rst_index",   cp0_index_o,  32'h0);
        check("rst_epc",     cp0_epc_o,    32'h0);
        check("rst_entryhi", cp0_entryhi_o, 32'h0);
        check("rst_taken",   32'(exc_taken_o), 32'd0);
        check("rst_ti",      32'(timer_int_o), 32'd0);
        read_chk("rst_compare", 5'd11, 32'hFFFF_FFFF);
        read_chk("rst_count",   5'd9,  32'h0);
        read_chk("rst_wired",   5'd6,  32'h0);

        // ---------------- MTC0 visibility ----------------
        cp0_wen_i  = 1'b1;
        cp0_addr_i = 5'd3;
        cp0_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check("mtc0_same_cycle_old", cp0_data_o, 32'h0);
        @(posedge clk); #1;
        cp0_wen_i = 1'b0;
        #1;
        check("mtc0_next_cycle", cp0_data_o, 32'h03FF_FFFF);

        // ---------------- exception priority table ----------------
        for (int i = 0; i < 11; i++) begin
            mtc0(5'd12, tbl[i].pre_status);
            cp0_addr_i        = 5'd8;
            hw_int_i          = tbl[i].hw;
            exc_addr_error_i  = tbl[i].ae;
            exc_tlb_mod_i     = tbl[i].mod;
            exc_tlb_refill_i  = tbl[i].refill;
            exc_tlb_invalid_i = tbl[i].inval;
            instr_syscall_i   = tbl[i].sys;
            exc_rw_i          = tbl[i].rw;
            epc_i             = tbl[i].epc;
            badvaddr_i        = tbl[i].badv;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("row%0d_taken", i), 32'(exc_taken_o), 32'(e.taken));
            if (e.taken)
                check($sformatf("row%0d_vector", i), exc_vector_o, e.vec);
            @(posedge clk); #1;
            clear_exc();
            #1;
            check($sformatf("row%0d_exccode", i), 32'(cp0_cause_o[6:2]), 32'(e.code));
            check($sformatf("row%0d_exl", i), 32'(cp0_status_o[1]), 32'(e.exl));
            check($sformatf("row%0d_epc", i), cp0_epc_o, e.epc_exp);
            check($sformatf("row%0d_badvaddr", i), cp0_data_o, e.badv_exp);
            check($sformatf("row%0d_entryhi", i), cp0_entryhi_o, e.ehi_exp);
        end

        // ---------------- live IP, ERET, collisions ----------------
        mtc0(5'd12, 32'h0000_FC01);
        hw_int_i = 6'h01;
        @(negedge clk);
        check("ip2_live", 32'(cp0_cause_o[10]), 32'd1);
        check("int_taken", 32'(exc_taken_o), 32'd1);
        @(posedge clk); #1;
        hw_int_i = '0;
        check("int_exl_set", 32'(cp0_status_o[1]), 32'd1);
        instr_eret_i = 1'b1;
        @(posedge clk); #1;
        instr_eret_i = 1'b0;
        check("eret_clears_exl", 32'(cp0_status_o[1]), 32'd0);
        // ERET + SYSCALL + MTC0 EntryLo0 in one cycle: the exception wins
        instr_eret_i    = 1'b1;
        instr_syscall_i = 1'b1;
        cp0_wen_i       = 1'b1;
        cp0_addr_i      = 5'd2;
        cp0_data_i      = 32'h0000_0123;
        @(negedge clk);
        check("eret_sys_taken", 32'(exc_taken_o), 32'd1);
        @(posedge clk); #1;
        clear_exc();
        cp0_wen_i = 1'b0;
        check("eret_sys_exl", 32'(cp0_status_o[1]), 32'd1);
        check("eret_sys_code", 32'(cp0_cause_o[6:2]), 32'd8);
        read_chk("mtc0_dropped", 5'd2, 32'h0);

        // ---------------- timer ----------------
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (timer_int_o) begin
                n = k;
                break;
            end
        end
        // Count reaches 5 after COUNT_DIV*5 edges from its write; TI one edge
        // later; the loop starts one edge after the Count write.
        check("timer_latency", 32'(n), 32'(COUNT_DIV * 5));
        check("timer_cause_ti", 32'(cp0_cause_o[30]), 32'd1);
        check("timer_cause_ip7", 32'(cp0_cause_o[15]), 32'd1);
        read_chk("timer_count", 5'd9, 32'd5);
        mtc0(5'd11, 32'd100);
        check("compare_clears_ti", 32'(timer_int_o), 32'd0);
        read_chk("count_after", 5'd9, 32'd6);
        cpu_pause_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        read_chk("count_paused", 5'd9, 32'd6);
        cpu_pause_i = 1'b0;

        // ---------------- Random / Wired ----------------
        mtc0(5'd6, 32'd12);
        check("random_after_wired", cp0_random_o, 32'd15);
        rnd_exp = '{32'd14, 32'd13, 32'd12, 32'd15, 32'd14};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("random_seq%0d", k), cp0_random_o, rnd_exp[k]);
        end
        cpu_pause_i     = 1'b1;
        instr_syscall_i = 1'b1;
        @(negedge clk);
        check("pause_blocks_exc", 32'(exc_taken_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("random_paused", cp0_random_o, 32'd14);
        instr_syscall_i = 1'b0;
        cpu_pause_i     = 1'b0;
        @(posedge clk); #1;
        check("random_resume", cp0_random_o, 32'd13);
        mtc0(5'd6, 32'd20);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("random_wired_big%0d", k), cp0_random_o, 32'd15);
        end

        // ---------------- TLBP ----------------
        tlb_probe_valid_i = 1'b1;
        tlb_probe_hit_i   = 1'b0;
        @(posedge clk); #1;
        check("tlbp_miss", cp0_index_o, 32'h8000_0000);
        tlb_probe_hit_i   = 1'b1;
        tlb_probe_index_i = 4'd9;
        @(posedge clk); #1;
        check("tlbp_hit", cp0_index_o, 32'h0000_0009);
        tlb_probe_index_i = 4'd5;
        cp0_wen_i         = 1'b1;
        cp0_addr_i        = 5'd0;
        cp0_data_i        = 32'd3;
        @(posedge clk); #1;
        cp0_wen_i         = 1'b0;
        tlb_probe_valid_i = 1'b0;
        check("tlbp_beats_mtc0", cp0_index_o, 32'h0000_0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
